// File: rtl/debug_ctrl_pkg.sv
// Shared definitions for the debug controller: default parameter values,
// FSM state encoding and the step-length helper.
package debug_ctrl_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DIGITS   = 8;
   localparam int DEF_SCAN_DIV = 16;

   // Width of the step_cnt input and of the internal step counter
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      st_halt  = 2'd0,
      st_step  = 2'd1,
      st_run   = 2'd2,
      st_break = 2'd3
   } state_t;

   // A requested step length of zero still executes one CPU cycle
   function automatic logic [CNT_W-1:0] step_len(input logic [CNT_W-1:0] n);
      return (n == '0) ? CNT_W'(1) : n;
   endfunction

endpackage

// File: rtl/debug_ctrl_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector. Produces one
// single-cycle pulse per rising edge of the asynchronous input.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic [2:0] sync_q;

   // Shift the asynchronous input through the synchroniser and history flop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments give every flop the value from before the edge; blocking ones would collapse the chain.
         sync_q <= {sync_q[1:0], d};
      end
   end

   assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/debug_ctrl.sv
// Debug controller: gates the CPU through cpu_en (free-run, multi-cycle step,
// PC breakpoint), steps an inspection address and scans a view word onto a
// multiplexed hex display.
module debug_ctrl
   import debug_ctrl_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DIGITS   = DEF_DIGITS,
   parameter int SCAN_DIV = DEF_SCAN_DIV
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       step,
   input  logic                       valid,
   input  logic [CNT_W-1:0]           step_cnt,
   input  logic                       bp_en,
   input  logic [ADDR_W-1:0]          bp_addr,
   input  logic [ADDR_W-1:0]          pc,
   input  logic [DATA_W-1:0]          view_data,
   output logic                       cpu_en,
   output logic                       halted,
   output logic                       bp_hit,
   output logic [ADDR_W-1:0]          view_addr,
   output logic [$clog2(DIGITS)-1:0]  an,
   output logic [3:0]                 seg
);

   localparam int AN_W  = $clog2(DIGITS);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   // View word zero-extended so every digit index selects a defined nibble
   localparam int PAD_W = (DIGITS * 4 > DATA_W) ? DIGITS * 4 : DATA_W;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             step_p, valid_p;
   logic             hit;

   logic [DIV_W-1:0] div;
   logic [AN_W-1:0]  an_next;
   logic             scan_tc;
   logic [PAD_W-1:0] view_wide;
   logic [3:0]       nib_next;

   edge_sync u_step_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (step),
      .pulse (step_p)
   );

   edge_sync u_valid_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (valid),
      .pulse (valid_p)
   );

   assign hit = bp_en && (pc == bp_addr);

   // State and step-counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= st_halt;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state logic; step pulses outside HALT/BREAK are simply not consumed
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         st_halt: begin
            if (run) begin
               state_n = st_run;
            end else if (step_p) begin
               state_n = st_step;
               cnt_n   = step_len(step_cnt);
            end
         end
         st_step: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state_n = st_halt;
         end
         st_run: begin
            if (hit)       state_n = st_break;
            else if (!run) state_n = st_halt;
         end
         st_break: begin
            if (step_p) begin
               state_n = st_step;
               cnt_n   = step_len(step_cnt);
            end else if (!run) begin
               state_n = st_halt;
            end
         end
         default: state_n = st_halt;
      endcase
   end

   // cpu_en is combinational so it drops in the very cycle a breakpoint
   // matches or run is released, and immediately on reset.
   assign cpu_en = (state == st_step) || ((state == st_run) && run && !hit);
   assign halted = (state == st_halt) || (state == st_break);
   assign bp_hit = (state == st_break);

   // Inspection address, advanced by each valid pulse in any state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         view_addr <= '0;
      else if (valid_p) view_addr <= view_addr + ADDR_W'(1);
   end

   assign scan_tc   = (div == DIV_W'(SCAN_DIV - 1));
   assign an_next   = an + AN_W'(1);
   assign view_wide = PAD_W'(view_data);
   assign nib_next  = view_wide[{an_next, 2'b00} +: 4];

   // Display scan: hold each digit SCAN_DIV cycles, then load the next one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= '0;
         an  <= '0;
         seg <= '0;
      end else if (scan_tc) begin
         div <= '0;
         an  <= an_next;
         seg <= nib_next;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

endmodule
